ks_data_path_gen: RTL

//  Parametrised K&S processor data path: PC, instruction register, opcode decoder, register file,
//  4-op ALU (ADD/AND/OR/SUB), registered flags. Driven cycle-by-cycle by the K&S control unit.

---
 rtl/ks_data_path_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ks_data_path_gen.sv
// K&S data path: PC, IR, opcode decode, register file, 4-op ALU, registered flags; decode/ALU combinational, state 1 cycle.
// Driven strictly by the control unit, no backpressure. Define KS_REG0_ZERO_EN to hard-wire reg[0] to zero.
package ks_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
  } decoded_instruction_type;
endpackage

module ks_data_path_gen #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            branch,
  input  logic                            pc_enable,
  input  logic                            ir_enable,
  input  logic                            addr_sel,
  input  logic                            c_sel,
  input  logic [1:0]                      operation,
  input  logic                            write_reg_enable,
  input  logic                            flags_reg_enable,
  output ks_pkg::decoded_instruction_type decoded_instruction,
  output logic                            zero_op,
  output logic                            neg_op,
  output logic                            unsigned_overflow,
  output logic                            signed_overflow,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               data_out,
  input  logic [DATA_W-1:0]               data_in
);
  import ks_pkg::*;

  localparam int RSEL_W = $clog2(NUM_REGS);
  localparam int MSB    = DATA_W - 1;
`ifdef KS_REG0_ZERO_EN
  localparam logic REG0_ZERO = 1'b1;
`else
  localparam logic REG0_ZERO = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              zero_q, neg_q, uov_q, sov_q;

  logic [7:0]        opcode;
  logic [RSEL_W-1:0] a_addr, b_addr, c_addr;
  logic [ADDR_W-1:0] mem_addr;
  decoded_instruction_type dec;

  logic [DATA_W-1:0] bus_a, bus_b, alu_res, wr_dat;
  logic [DATA_W:0]   sum_ext;
  logic              alu_uov, alu_sov, reg_we;
  logic              unused_ir;

  assign opcode    = ir_q[DATA_W-1 -: 8];
  assign unused_ir = ^ir_q;

  always_comb begin
    dec      = I_NOP;
    a_addr   = '0;
    b_addr   = '0;
    c_addr   = '0;
    mem_addr = '0;
    case (opcode)
      8'h81: begin
        dec      = I_LOAD;
        c_addr   = ir_q[ADDR_W+RSEL_W-1:ADDR_W];
        mem_addr = ir_q[ADDR_W-1:0];
      end
      8'h82: begin
        dec      = I_STORE;
        a_addr   = ir_q[ADDR_W+RSEL_W-1:ADDR_W];
        mem_addr = ir_q[ADDR_W-1:0];
      end
      8'h91: begin
        dec    = I_MOVE;
        c_addr = ir_q[2*RSEL_W-1:RSEL_W];
        a_addr = ir_q[RSEL_W-1:0];
        b_addr = ir_q[RSEL_W-1:0];
      end
      8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
        dec    = (opcode == 8'hA1) ? I_ADD : (opcode == 8'hA2) ? I_SUB :
                 (opcode == 8'hA3) ? I_AND : I_OR;
        a_addr = ir_q[RSEL_W-1:0];
        b_addr = ir_q[2*RSEL_W-1:RSEL_W];
        c_addr = ir_q[3*RSEL_W-1:2*RSEL_W];
      end
      8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B: begin
        dec      = (opcode == 8'h01) ? I_BRANCH : (opcode == 8'h02) ? I_BZERO :
                   (opcode == 8'h03) ? I_BNEG   : (opcode == 8'h05) ? I_BOV   :
                   (opcode == 8'h06) ? I_BNOV   : (opcode == 8'h0A) ? I_BNNEG : I_BNZERO;
        mem_addr = ir_q[ADDR_W-1:0];
      end
      8'hFF:   dec = I_HALT;
      default: dec = I_NOP;
    endcase
  end

  // Asynchronous reads see the pre-write contents, giving old-value read-during-write.
  assign bus_a = (REG0_ZERO && a_addr == '0) ? '0 : regs_q[a_addr];
  assign bus_b = (REG0_ZERO && b_addr == '0) ? '0 : regs_q[b_addr];

  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    case (operation)
      2'b00: begin
        sum_ext = {1'b0, bus_a} + {1'b0, bus_b};
        alu_res = sum_ext[DATA_W-1:0];
        alu_uov = sum_ext[DATA_W];
        alu_sov = (bus_a[MSB] == bus_b[MSB]) && (alu_res[MSB] != bus_a[MSB]);
      end
      2'b01: alu_res = bus_a & bus_b;
      2'b10: alu_res = bus_a | bus_b;
      default: begin
        // Missing carry out of a + ~b + 1 is the unsigned borrow.
        sum_ext = {1'b0, bus_a} + {1'b0, ~bus_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum_ext[DATA_W-1:0];
        alu_uov = ~sum_ext[DATA_W];
        alu_sov = (bus_a[MSB] != bus_b[MSB]) && (alu_res[MSB] != bus_a[MSB]);
      end
    endcase
  end

  assign wr_dat = c_sel ? alu_res : data_in;
  assign reg_we = write_reg_enable && !(REG0_ZERO && c_addr == '0);
  assign pc_d   = branch ? mem_addr : pc_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (pc_enable) pc_q <= pc_d;
      if (ir_enable) ir_q <= data_in;
      if (reg_we) regs_q[c_addr] <= wr_dat;
      if (flags_reg_enable) begin
        zero_q <= ~|alu_res;
        neg_q  <= alu_res[MSB];
        uov_q  <= alu_uov;
        sov_q  <= alu_sov;
      end
    end
  end

  assign decoded_instruction = dec;
  assign ram_addr            = addr_sel ? mem_addr : pc_q;
  assign data_out            = bus_a;
  assign zero_op             = zero_q;
  assign neg_op              = neg_q;
  assign unsigned_overflow   = uov_q;
  assign signed_overflow     = sov_q;
endmodule
